// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: runs LOAD, STORE and forward block COPY commands against
// a single-port memory with one-cycle registered read data, one response per command.
module dmem_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_len,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_CAP    = 3'd2,
    S_WR     = 3'd3,
    S_CP_RD  = 3'd4,
    S_CP_CAP = 3'd5,
    S_CP_WR  = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r;    // effective address, or COPY source pointer
  logic [ADDR_W-1:0]   dst_r;
  logic [ADDR_W-1:0]   remain_r;
  logic [ADDR_W-1:0]   len_r;
  logic [DATA_W-1:0]   data_r;    // STORE data, or COPY word buffer
  logic [DATA_W-1:0]   resp_data_r;
  logic                resp_err_r;

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_LOAD:  state_s = S_RD;
            OP_STORE: state_s = S_WR;
            OP_COPY:  state_s = (req_len == '0) ? S_RESP : S_CP_RD;
            default:  state_s = S_RESP;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD:     state_s = S_CAP;
      S_CAP:    state_s = S_RESP;
      S_WR:     state_s = S_RESP;
      S_CP_RD:  state_s = S_CP_CAP;
      S_CP_CAP: state_s = S_CP_WR;
      S_CP_WR:  state_s = (remain_r == ADDR_W'(1)) ? S_RESP : S_CP_RD;
      S_RESP:   state_s = resp_ready ? S_IDLE : S_RESP;
      default:  state_s = S_IDLE;
    endcase
  end

  // Memory strobes and handshake outputs decoded from registered state only.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_r)
      S_RD, S_CP_RD: begin
        mem_read = 1'b1;
        mem_addr = addr_r;
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_r;
        mem_wdata = data_r;
      end
      S_CP_WR: begin
        mem_write = 1'b1;
        mem_addr  = dst_r;
        mem_wdata = data_r;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
    req_ready  = (state_r == S_IDLE);
    busy       = (state_r != S_IDLE);
    resp_valid = (state_r == S_RESP);
    resp_data  = resp_data_r;
    resp_err   = resp_err_r;
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      addr_r      <= '0;
      dst_r       <= '0;
      remain_r    <= '0;
      len_r       <= '0;
      data_r      <= '0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            addr_r      <= (req_op == OP_COPY) ? req_base : req_base + req_offset;
            dst_r       <= req_dst;
            remain_r    <= req_len;
            len_r       <= req_len;
            data_r      <= req_wdata;
            resp_data_r <= '0;
            resp_err_r  <= (req_op == 2'b11);
          end
        end
        S_CAP:    resp_data_r <= mem_rdata;
        S_CP_CAP: data_r      <= mem_rdata;
        S_CP_WR: begin
          addr_r   <= addr_r + ADDR_W'(1);
          dst_r    <= dst_r + ADDR_W'(1);
          remain_r <= remain_r - ADDR_W'(1);
          if (remain_r == ADDR_W'(1)) begin
            resp_data_r <= {{(DATA_W-ADDR_W){1'b0}}, len_r};
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus a randomized
// command stream checked against an array-based memory/response reference model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [8:0]  req_base = 9'd0, req_offset = 9'd0, req_dst = 9'd0, req_len = 9'd0;
  logic [18:0] req_wdata = 19'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [18:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic [8:0]  mem_addr;
  logic [18:0] mem_wdata;
  logic        mem_write, mem_read;
  logic [18:0] mem_rdata;

  logic [18:0] mem [0:511];
  logic [18:0] ref_mem [0:511];
  logic [18:0] mem_seed;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0, wr_cnt = 0, acc_cnt = 0, rsp_cnt = 0, both_cnt = 0;
  logic [8:0] rd_addrs [$];

  dmem_access_ctrl #(.ADDR_W(9), .DATA_W(19)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_dst(req_dst), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] preload(input int i);
    return mem_seed ^ 19'(i * 4099) ^ 19'(i << 9);
  endfunction

  // Single-port memory with registered read data; refilled while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) mem[i] <= preload(i);
    end else begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read) mem_rdata <= mem[mem_addr];
    end
  end

  // Bus activity monitor.
  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_read) begin
        rd_cnt <= rd_cnt + 1;
        rd_addrs.push_back(mem_addr);
      end
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
      if (resp_valid && resp_ready) rsp_cnt <= rsp_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic issue(input logic [1:0] op, input logic [8:0] base, input logic [8:0] off,
                       input logic [18:0] wd, input logic [8:0] dst, input logic [8:0] len);
    int g = 0;
    while (!req_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    req_op = op; req_base = base; req_offset = off; req_wdata = wd;
    req_dst = dst; req_len = len; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_base = 9'($urandom); req_offset = 9'($urandom);
    req_wdata = 19'($urandom); req_dst = 9'($urandom); req_len = 9'($urandom);
  endtask

  task automatic wait_resp(input bit rnd_ready, output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 4000) begin
      if (rnd_ready) resp_ready = 1'($urandom);
      @(posedge clk); #1; cyc++;
    end
    resp_ready = 1'b0;
    if (!resp_valid) begin
      n_cmp++; n_err++;
      $display("FAIL resp_timeout: no response after %0d cycles", cyc);
    end
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // Reference model: returns expected response and applies memory effects.
  task automatic model_cmd(input logic [1:0] op, input logic [8:0] base, input logic [8:0] off,
                           input logic [18:0] wd, input logic [8:0] dst, input logic [8:0] len,
                           output logic [18:0] exp_data, output logic exp_err);
    logic [8:0] ea = base + off;
    logic [8:0] s = base;
    logic [8:0] d = dst;
    exp_err = 1'b0;
    exp_data = 19'd0;
    case (op)
      2'b00: exp_data = ref_mem[ea];
      2'b01: ref_mem[ea] = wd;
      2'b10: begin
        for (int i = 0; i < int'(len); i++) begin
          ref_mem[d] = ref_mem[s];
          s = s + 9'd1; d = d + 9'd1;
        end
        exp_data = {10'd0, len};
      end
      default: exp_err = 1'b1;
    endcase
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [8:0] base, input logic [8:0] off,
                         input logic [18:0] wd, input logic [8:0] dst, input logic [8:0] len);
    logic [18:0] ed; logic ee; int c;
    model_cmd(op, base, off, wd, dst, len, ed, ee);
    issue(op, base, off, wd, dst, len);
    wait_resp(1'b0, c);
    retire();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 512; i++) ref_mem[i] = preload(i);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
    n_cmp++; if (mem_addr !== 9'd0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    n_cmp++; if ({busy, resp_err, resp_data} !== 21'd0) begin n_err++; $display("FAIL reset_misc: got %h want 0", {busy, resp_err, resp_data}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int c; int w0 = wr_cnt;
    logic [18:0] ed; logic ee;
    model_cmd(2'b01, 9'h1F0, 9'h015, 19'h5A5A5, 9'd0, 9'd0, ed, ee);
    issue(2'b01, 9'h1F0, 9'h015, 19'h5A5A5, 9'd0, 9'd0);
    n_cmp++; if ({mem_write, mem_read, mem_addr, mem_wdata} !== {2'b10, 9'h005, 19'h5A5A5}) begin
      n_err++; $display("FAIL store_bus: got w=%b r=%b a=%h d=%h want w=1 r=0 a=005 d=5a5a5", mem_write, mem_read, mem_addr, mem_wdata);
    end
    wait_resp(1'b0, c);
    n_cmp++; if (c !== 1) begin n_err++; $display("FAIL store_latency: got %0d want 1", c); end
    n_cmp++; if ({resp_err, resp_data} !== 20'd0) begin n_err++; $display("FAIL store_resp: got err=%b data=%h want 0/0", resp_err, resp_data); end
    retire();
    n_cmp++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL store_write_count: got %0d want 1", wr_cnt - w0); end
    issue(2'b00, 9'h005, 9'h000, 19'd0, 9'd0, 9'd0);
    wait_resp(1'b0, c);
    n_cmp++; if (c !== 2) begin n_err++; $display("FAIL load_latency: got %0d want 2", c); end
    n_cmp++; if (resp_data !== 19'h5A5A5) begin n_err++; $display("FAIL load_data: got %h want 5a5a5", resp_data); end
    retire();
    n_cmp++; if ({resp_valid, resp_data} !== 20'd0) begin n_err++; $display("FAIL retire_clear: got v=%b d=%h want 0", resp_valid, resp_data); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL retire_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_copy();
    logic [18:0] ed; logic ee;
    int c;
    for (int k = 0; k < 4; k++) run_cmd(2'b01, 9'h010, 9'(k), 19'(k + 1), 9'd0, 9'd0);
    model_cmd(2'b10, 9'h010, 9'd0, 19'd0, 9'h100, 9'd4, ed, ee);
    issue(2'b10, 9'h010, 9'h0AA, 19'd0, 9'h100, 9'd4);
    c = 0;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if ({mem_read, mem_write} !== {1'(i % 3 == 0), 1'(i % 3 == 2)}) begin
        n_err++; $display("FAIL copy_pattern[%0d]: got r=%b w=%b want r=%b w=%b", i, mem_read, mem_write, i % 3 == 0, i % 3 == 2);
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL copy_latency: resp_valid=%b after 12 cycles want 1", resp_valid); end
    wait_resp(1'b0, c);
    n_cmp++; if (resp_data !== ed) begin n_err++; $display("FAIL copy_count: got %h want %h", resp_data, ed); end
    retire();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (mem[9'h100 + k] !== 19'(k + 1)) begin n_err++; $display("FAIL copy_dst[%0d]: got %h want %h", k, mem[9'h100 + k], k + 1); end
    end
  endtask

  task automatic test_copy_wrap();
    logic [18:0] ed; logic ee;
    int c; int r0, w0;
    rd_addrs.delete();
    model_cmd(2'b10, 9'h1FE, 9'd0, 19'd0, 9'h000, 9'd3, ed, ee);
    issue(2'b10, 9'h1FE, 9'd0, 19'd0, 9'h000, 9'd3);
    wait_resp(1'b0, c);
    n_cmp++; if (c !== 9) begin n_err++; $display("FAIL wrap_latency: got %0d want 9", c); end
    n_cmp++;
    if (rd_addrs.size() != 3 || rd_addrs[0] !== 9'h1FE || rd_addrs[1] !== 9'h1FF || rd_addrs[2] !== 9'h000) begin
      n_err++; $display("FAIL wrap_read_addrs: got %p want 1fe 1ff 000", rd_addrs);
    end
    n_cmp++; if (resp_data !== 19'd3) begin n_err++; $display("FAIL wrap_count: got %h want 3", resp_data); end
    retire();
    r0 = rd_cnt; w0 = wr_cnt;
    issue(2'b10, 9'h055, 9'd0, 19'd0, 9'h0AA, 9'd0);
    wait_resp(1'b0, c);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL len0_latency: got %0d want 0", c); end
    n_cmp++; if (resp_data !== 19'd0) begin n_err++; $display("FAIL len0_data: got %h want 0", resp_data); end
    retire();
    n_cmp++; if (rd_cnt - r0 + wr_cnt - w0 !== 0) begin n_err++; $display("FAIL len0_strobes: got %0d want 0", rd_cnt - r0 + wr_cnt - w0); end
  endtask

  task automatic test_reserved_hold();
    int c; int s0 = rd_cnt + wr_cnt;
    issue(2'b11, 9'($urandom), 9'($urandom), 19'($urandom), 9'($urandom), 9'($urandom));
    wait_resp(1'b0, c);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL rsv_latency: got %0d want 0", c); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({resp_valid, resp_err, resp_data, req_ready, busy} !== {2'b11, 19'd0, 1'b0, 1'b1}) begin
        n_err++; $display("FAIL rsv_hold[%0d]: got v=%b e=%b d=%h rdy=%b busy=%b want 1 1 0 0 1", i, resp_valid, resp_err, resp_data, req_ready, busy);
      end
      @(posedge clk); #1;
    end
    retire();
    n_cmp++; if ({resp_valid, resp_err} !== 2'b00) begin n_err++; $display("FAIL rsv_clear: got %b want 00", {resp_valid, resp_err}); end
    n_cmp++; if (rd_cnt + wr_cnt - s0 !== 0) begin n_err++; $display("FAIL rsv_strobes: got %0d want 0", rd_cnt + wr_cnt - s0); end
  endtask

  task automatic test_random();
    logic [18:0] ed; logic ee;
    logic [1:0] op; logic [8:0] b, o, d, l; logic [18:0] wd;
    int c, bad; int a0 = acc_cnt, p0 = rsp_cnt;
    for (int n = 0; n < 200; n++) begin
      op = 2'($urandom); b = 9'($urandom); o = 9'($urandom); d = 9'($urandom);
      l = 9'($urandom_range(0, 6)); wd = 19'($urandom);
      if (n % 8 == 0) begin d = b + 9'($urandom_range(1, 3)); op = 2'b10; end
      model_cmd(op, b, o, wd, d, l, ed, ee);
      issue(op, b, o, wd, d, l);
      wait_resp(1'b1, c);
      n_cmp++;
      if ({resp_err, resp_data} !== {ee, ed}) begin
        n_err++; $display("FAIL rand_resp[%0d] op=%b: got err=%b data=%h want err=%b data=%h", n, op, resp_err, resp_data, ee, ed);
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      n_cmp++;
      if ({resp_valid, resp_err, resp_data} !== {1'b1, ee, ed}) begin
        n_err++; $display("FAIL rand_stable[%0d]: got v=%b err=%b data=%h want 1 %b %h", n, resp_valid, resp_err, resp_data, ee, ed);
      end
      retire();
    end
    n_cmp++; if ((acc_cnt - a0) !== 200 || (rsp_cnt - p0) !== 200) begin
      n_err++; $display("FAIL rand_resp_count: accepted %0d responded %0d want 200/200", acc_cnt - a0, rsp_cnt - p0);
    end
    n_cmp++; if (both_cnt !== 0) begin n_err++; $display("FAIL rd_wr_overlap: got %0d cycles want 0", both_cnt); end
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mem_contents: got %0d differing words want 0", bad); end
  endtask

  task automatic test_reset_midcopy();
    int g = 0; int p0 = rsp_cnt; int seen = 0;
    issue(2'b10, 9'h000, 9'd0, 19'd0, 9'h080, 9'd5);
    while (!mem_write && g < 20) begin @(posedge clk); #1; g++; end
    n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL midcopy_reach_wr: mem_write=%b want 1", mem_write); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_write, mem_read, busy, req_ready} !== 4'b0001) begin
      n_err++; $display("FAIL midcopy_async_drop: got w=%b r=%b busy=%b rdy=%b want 0 0 0 1", mem_write, mem_read, busy, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0 || rsp_cnt !== p0) begin n_err++; $display("FAIL midcopy_no_resp: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    mem_seed = 19'($urandom);
    test_reset();
    test_store_load();
    test_copy();
    test_copy_wrap();
    test_reserved_hold();
    test_random();
    test_reset_midcopy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
